// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: branch/jump opcodes, the canonical bubble word
// and the two-state IF/ID slot encoding.
package mips_pkg;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    SLOT_SQUASHED = 1'b0,
    SLOT_VALID    = 1'b1
  } slot_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational ID-stage branch decoder: classifies the opcode, evaluates the
// condition and produces the word offset that fetch adds to its current PC.
module branch_cond
  import mips_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] Rs_val,
  input  logic [31:0] Rt_val,
  input  logic [31:0] instruction,
  input  logic [31:0] ID_PC,
  output logic        is_branch,
  output logic        cond,
  output logic [31:0] offset
);

  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] jump_delta;
  logic [31:0] imm_ext;
  logic        unused_opfield;

  // The opcode arrives separately, so the top six instruction bits go unused.
  assign unused_opfield = ^instruction[31:26];

  // Fetch already sits at pc4 while the jump is in ID, so the jump is
  // expressed as a word delta relative to pc4 rather than an absolute target.
  assign pc4         = ID_PC + 32'd4;
  assign jump_target = {pc4[31:28], instruction[25:0], 2'b00};
  assign jump_delta  = jump_target - pc4;
  assign imm_ext     = sign_ext16(instruction[15:0]);

  always_comb begin
    is_branch = 1'b0;
    cond      = 1'b0;
    offset    = imm_ext;
    case (op)
      OP_BEQ: begin
        is_branch = 1'b1;
        cond      = (Rs_val == Rt_val);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        cond      = (Rs_val != Rt_val);
      end
      OP_BLEZ: begin
        is_branch = 1'b1;
        cond      = ($signed(Rs_val) <= 32'sd0);
      end
      OP_BGTZ: begin
        is_branch = 1'b1;
        cond      = ($signed(Rs_val) > 32'sd0);
      end
      OP_J: begin
        is_branch = 1'b1;
        cond      = 1'b1;
        offset    = $signed(jump_delta) >>> 2;
      end
      default: begin
        is_branch = 1'b0;
        cond      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/if_id_branch.sv
// IF/ID pipeline register with zero-cycle branch resolution in ID, squash of
// the single wrong-path fetch, and saturating branch performance counters.
module if_id_branch
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP     = NOP_WORD,
  parameter int          COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        IF_PC,
  input  logic [31:0]        IF_Instruction,
  input  logic [31:0]        Rs_val,
  input  logic [31:0]        Rt_val,
  output logic [4:0]         Rs_addr,
  output logic [4:0]         Rt_addr,
  output logic               Br_taken,
  output logic [31:0]        Br_offset,
  output logic [31:0]        ID_PC,
  output logic [31:0]        ID_Instruction,
  output logic               ID_valid,
  output logic [COUNT_W-1:0] Br_count,
  output logic [COUNT_W-1:0] Taken_count
);

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  slot_e       slot_q;
  slot_e       slot_d;
  logic        is_branch;
  logic        cond;
  logic [31:0] offset;

  assign Rs_addr = ID_Instruction[25:21];
  assign Rt_addr = ID_Instruction[20:16];

  branch_cond u_branch_cond (
    .op          (ID_Instruction[31:26]),
    .Rs_val      (Rs_val),
    .Rt_val      (Rt_val),
    .instruction (ID_Instruction),
    .ID_PC       (ID_PC),
    .is_branch   (is_branch),
    .cond        (cond),
    .offset      (offset)
  );

  assign Br_taken  = ID_valid & cond;
  assign Br_offset = Br_taken ? offset : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= SLOT_SQUASHED;
    end else begin
      slot_q <= slot_d;
    end
  end

  // A squashed slot holds NOP and can never redirect, so it always recovers.
  always_comb begin
    slot_d = SLOT_VALID;
    if (slot_q == SLOT_VALID && Br_taken) begin
      slot_d = SLOT_SQUASHED;
    end
  end

  always_comb begin
    ID_valid = (slot_q == SLOT_VALID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_PC          <= 32'd0;
      ID_Instruction <= NOP;
    end else begin
      ID_PC          <= IF_PC;
      ID_Instruction <= Br_taken ? NOP : IF_Instruction;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Br_count    <= '0;
      Taken_count <= '0;
    end else begin
      if (ID_valid && is_branch && Br_count != CNT_MAX) begin
        Br_count <= Br_count + CNT_ONE;
      end
      if (Br_taken && Taken_count != CNT_MAX) begin
        Taken_count <= Taken_count + CNT_ONE;
      end
    end
  end

endmodule
